// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Contents: FSM state encodings, request size encodings, default-geometry
// derived widths and the alignment / byte-strobe helper functions.
package dcache_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_REFILL_REQ = 3'd1;
  localparam state_t ST_REFILL     = 3'd2;
  localparam state_t ST_WRITE      = 3'd3;
  localparam state_t ST_RESP       = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  // Geometry of the default configuration; instances recompute these
  // from their own parameters.
  localparam int ADDR_W_DEF      = 32;
  localparam int INDEX_BITS_DEF  = 4;
  localparam int OFFSET_BITS_DEF = 4;
  localparam int TAG_W = ADDR_W_DEF - INDEX_BITS_DEF - OFFSET_BITS_DEF - 2;
  localparam int LINES = 1 << INDEX_BITS_DEF;
  localparam int WORDS = 1 << OFFSET_BITS_DEF;

  // 1 when the access cannot be serviced: illegal size or not naturally aligned.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte enables of an aligned access inside its 32-bit word.
  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] strb;
    case (size)
      SZ_BYTE: strb = 4'b0001 << lo;
      SZ_HALF: strb = 4'b0011 << lo;
      SZ_WORD: strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/dcache_store_merge.sv
// Combinational store-lane merge.
// Ports: size/addr_lo/wdata describe the store (data right-aligned),
// old_word is the word currently held (array or refill beat);
// merged is old_word with the enabled lanes replaced, lane_data is the
// store data replicated across lanes, strb the byte enables.
module dcache_store_merge
  import dcache_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] merged,
  output logic [31:0] lane_data,
  output logic [3:0]  strb
);

  // Replicate store data across lanes, derive enables, merge into old word.
  always_comb begin
    lane_data = 32'h0000_0000;
    case (size)
      SZ_BYTE: lane_data = {4{wdata[7:0]}};
      SZ_HALF: lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
    strb   = byte_strobe(size, addr_lo);
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = lane_data[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_dm_param.sv
// Direct-mapped, write-through, write-allocate data cache.
// Ports: core side req_* / resp_* (valid-ready request, one-cycle response
// pulse), flush, refill read port mem_rd_* (request/grant then N beats),
// write-through port mem_wr_* (request held until ack) and saturating
// hit/miss statistics counters.
module dcache_dm_param
  import dcache_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 4,
  parameter int CNT_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  input  logic              flush,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic [3:0]        mem_wr_strb,
  input  logic              mem_wr_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS - 2;
  localparam int N_LINES  = 1 << INDEX_BITS;
  localparam int N_WORDS  = 1 << OFFSET_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                   state_r;
  logic [N_LINES-1:0]       valid_r;
  logic [TAG_BITS-1:0]      tag_mem  [N_LINES];
  logic [31:0]              data_mem [N_LINES*N_WORDS];

  logic                     write_r;
  logic [1:0]               size_r;
  logic [ADDR_W-1:0]        addr_r;
  logic [31:0]              wdata_r;
  logic [OFFSET_BITS-1:0]   beat_cnt_r;

  logic [31:0]              resp_rdata_r;
  logic                     resp_err_r;
  logic [ADDR_W-1:0]        mem_rd_addr_r;
  logic [ADDR_W-1:0]        mem_wr_addr_r;
  logic [31:0]              mem_wr_data_r;
  logic [3:0]               mem_wr_strb_r;
  logic [CNT_W-1:0]         hit_count_r;
  logic [CNT_W-1:0]         miss_count_r;

  logic [1:0]               cur_size_s;
  logic [ADDR_W-1:0]        cur_addr_s;
  logic [31:0]              cur_wdata_s;
  logic [INDEX_BITS-1:0]    idx_s;
  logic [OFFSET_BITS-1:0]   woff_s;
  logic [TAG_BITS-1:0]      tag_s;
  logic                     accept_s;
  logic                     bad_s;
  logic                     hit_s;
  logic                     refill_beat_s;
  logic                     beat_is_target_s;
  logic [31:0]              line_word_s;
  logic [31:0]              old_word_s;
  logic [31:0]              merged_s;
  logic [31:0]              lane_s;
  logic [3:0]               strb_s;

  // In IDLE the live request drives lookup; afterwards the captured copy does.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_size_s  = req_size;
      cur_addr_s  = req_addr;
      cur_wdata_s = req_wdata;
    end else begin
      cur_size_s  = size_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
    end
  end

  assign idx_s            = cur_addr_s[OFFSET_BITS+2 +: INDEX_BITS];
  assign woff_s           = cur_addr_s[2 +: OFFSET_BITS];
  assign tag_s            = cur_addr_s[ADDR_W-1 -: TAG_BITS];
  assign accept_s         = req_valid && (state_r == ST_IDLE);
  assign bad_s            = access_bad(req_size, req_addr[1:0]);
  assign hit_s            = valid_r[idx_s] && (tag_mem[idx_s] == tag_s);
  assign refill_beat_s    = (state_r == ST_REFILL) && mem_rd_valid;
  assign beat_is_target_s = (beat_cnt_r == woff_s);
  assign line_word_s      = data_mem[{idx_s, woff_s}];
  // During refill the store merges into the incoming beat, not the stale array word.
  assign old_word_s       = (state_r == ST_REFILL) ? mem_rd_data : line_word_s;

  dcache_store_merge u_merge (
    .size      (cur_size_s),
    .addr_lo   (cur_addr_s[1:0]),
    .wdata     (cur_wdata_s),
    .old_word  (old_word_s),
    .merged    (merged_s),
    .lane_data (lane_s),
    .strb      (strb_s)
  );

  // Tag and data arrays: refill beats and store merges, intentionally unreset.
  always_ff @(posedge clock) begin
    if (accept_s && !bad_s && hit_s && req_write) begin
      data_mem[{idx_s, woff_s}] <= merged_s;
    end else if (refill_beat_s) begin
      data_mem[{idx_s, beat_cnt_r}] <= (write_r && beat_is_target_s) ? merged_s : mem_rd_data;
    end
    if (refill_beat_s && (&beat_cnt_r)) begin
      tag_mem[idx_s] <= tag_s;
    end
  end

  // Control FSM, valid bits, captured request, output registers and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      valid_r       <= '0;
      write_r       <= 1'b0;
      size_r        <= 2'd0;
      addr_r        <= '0;
      wdata_r       <= 32'h0000_0000;
      beat_cnt_r    <= '0;
      resp_rdata_r  <= 32'h0000_0000;
      resp_err_r    <= 1'b0;
      mem_rd_addr_r <= '0;
      mem_wr_addr_r <= '0;
      mem_wr_data_r <= 32'h0000_0000;
      mem_wr_strb_r <= 4'b0000;
      hit_count_r   <= '0;
      miss_count_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            write_r      <= req_write;
            size_r       <= req_size;
            addr_r       <= req_addr;
            wdata_r      <= req_wdata;
            resp_rdata_r <= 32'h0000_0000;
            if (bad_s) begin
              resp_err_r <= 1'b1;
              state_r    <= ST_RESP;
            end else if (hit_s) begin
              if (hit_count_r != CNT_MAX) begin
                hit_count_r <= hit_count_r + CNT_ONE;
              end
              if (req_write) begin
                mem_wr_addr_r <= {cur_addr_s[ADDR_W-1:2], 2'b00};
                mem_wr_data_r <= lane_s;
                mem_wr_strb_r <= strb_s;
                state_r       <= ST_WRITE;
              end else begin
                resp_rdata_r <= line_word_s;
                state_r      <= ST_RESP;
              end
            end else begin
              if (miss_count_r != CNT_MAX) begin
                miss_count_r <= miss_count_r + CNT_ONE;
              end
              // Line is being overwritten: keep it invalid until the last beat lands.
              valid_r[idx_s] <= 1'b0;
              mem_rd_addr_r  <= {cur_addr_s[ADDR_W-1:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
              beat_cnt_r     <= '0;
              state_r        <= ST_REFILL_REQ;
            end
          end else if (flush) begin
            valid_r <= '0;
          end
        end
        ST_REFILL_REQ: begin
          if (mem_rd_gnt) begin
            state_r <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (mem_rd_valid) begin
            beat_cnt_r <= beat_cnt_r + 1'b1;
            if (!write_r && beat_is_target_s) begin
              resp_rdata_r <= mem_rd_data;
            end
            if (&beat_cnt_r) begin
              valid_r[idx_s] <= 1'b1;
              if (write_r) begin
                mem_wr_addr_r <= {cur_addr_s[ADDR_W-1:2], 2'b00};
                mem_wr_data_r <= lane_s;
                mem_wr_strb_r <= strb_s;
                state_r       <= ST_WRITE;
              end else begin
                state_r <= ST_RESP;
              end
            end
          end
        end
        ST_WRITE: begin
          if (mem_wr_ack) begin
            state_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          resp_rdata_r <= 32'h0000_0000;
          resp_err_r   <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state_r == ST_IDLE);
  assign resp_valid  = (state_r == ST_RESP);
  assign resp_rdata  = resp_rdata_r;
  assign resp_err    = resp_err_r;
  assign mem_rd_req  = (state_r == ST_REFILL_REQ);
  assign mem_rd_addr = mem_rd_addr_r;
  assign mem_wr_req  = (state_r == ST_WRITE);
  assign mem_wr_addr = mem_wr_addr_r;
  assign mem_wr_data = mem_wr_data_r;
  assign mem_wr_strb = mem_wr_strb_r;
  assign hit_count   = hit_count_r;
  assign miss_count  = miss_count_r;

endmodule

// File: tb/tb_dcache_dm_param.sv
// Scoreboard bench for dcache_dm_param: directed requests push expected
// responses / write-through beats into queues, monitors pop and compare.
module tb_dcache_dm_param;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        flush;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_gnt;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_wr_req;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic        mem_wr_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int errors = 0;
  int checks = 0;
  int beats_sent = 0;
  int rd_grants = 0;
  int wr_done = 0;
  int ack_delay = 0;
  logic [31:0] last_rd_base = 32'h0;

  resp_t exp_q[$];
  wr_t   exp_wr_q[$];
  logic [31:0] bmem [logic [31:0]];

  dcache_dm_param dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .flush        (flush),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_gnt   (mem_rd_gnt),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_req   (mem_wr_req),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_strb  (mem_wr_strb),
    .mem_wr_ack   (mem_wr_ack),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {8'hA5, 8'h00, a[15:0]};
  endfunction

  // Response monitor: every resp_valid pops one expectation.
  initial begin
    resp_t e;
    forever begin
      @(negedge clock);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: actual rdata=0x%08h err=%0b, required no response", resp_rdata, resp_err);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        end
      end
    end
  end

  // Refill responder: grant immediately, 16 beats with occasional gaps, aborts on reset.
  initial begin
    logic [31:0] base;
    mem_rd_gnt = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data = 32'h0;
    forever begin
      @(negedge clock);
      if (reset && mem_rd_req) begin
        base = mem_rd_addr;
        last_rd_base = base;
        rd_grants++;
        mem_rd_gnt = 1'b1;
        @(negedge clock);
        mem_rd_gnt = 1'b0;
        for (int b = 0; b < 16; b++) begin
          if (!reset) break;
          mem_rd_valid = 1'b1;
          mem_rd_data = mem_read(base + 32'(4 * b));
          beats_sent++;
          @(negedge clock);
          mem_rd_valid = 1'b0;
          if (b % 3 == 1) @(negedge clock);
        end
        mem_rd_valid = 1'b0;
      end
    end
  end

  // Write-through responder and write scoreboard.
  initial begin
    wr_t e;
    logic [31:0] w;
    mem_wr_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && mem_wr_req) begin
        for (int i = 0; i < ack_delay; i++) begin
          chk("wr_hold_ready_low", {31'd0, req_ready}, 32'd0);
          chk("wr_hold_req", {31'd0, mem_wr_req}, 32'd1);
          @(negedge clock);
        end
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: actual addr=0x%08h data=0x%08h, required none", mem_wr_addr, mem_wr_data);
        end else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", mem_wr_addr, e.addr);
          chk("wr_data", mem_wr_data, e.data);
          chk("wr_strb", {28'd0, mem_wr_strb}, {28'd0, e.strb});
        end
        w = mem_read(mem_wr_addr);
        for (int k = 0; k < 4; k++) begin
          if (mem_wr_strb[k]) w[8*k +: 8] = mem_wr_data[8*k +: 8];
        end
        bmem[mem_wr_addr] = w;
        wr_done++;
        mem_wr_ack = 1'b1;
        @(negedge clock);
        mem_wr_ack = 1'b0;
      end
    end
  end

  // Issue one request, queue its expected response, return accept-to-response latency.
  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_e, output int lat);
    int n;
    exp_q.push_back('{rdata: exp_rd, err: exp_e});
    @(negedge clock);
    req_valid = 1'b1;
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
      req_valid = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = ~w;
    req_size  = ~sz;
    req_addr  = ~a;
    req_wdata = ~wd;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!resp_valid && lat < 300);
    if (!resp_valid) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int b0;
    int g0;
    int w0;
    int n;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = 2'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    flush     = 1'b0;
    reset     = 1'b0;
    bmem[32'h0000_0004] = 32'h0DCC_0BAA;
    bmem[32'h0000_0404] = 32'h1122_3344;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_rd_req", {31'd0, mem_rd_req}, 32'd0);
    chk("rst_mem_wr_req", {31'd0, mem_wr_req}, 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    reset = 1'b1;

    // Cold miss then hit.
    b0 = beats_sent;
    issue(1'b0, 2'd2, 32'h4, 32'h0, 32'h0DCC_0BAA, 1'b0, lat);
    chk("miss1_beats", 32'(beats_sent - b0), 32'd16);
    chk("miss1_rd_base", last_rd_base, 32'h0);
    chk("miss1_miss_count", miss_count, 32'd1);
    chk("miss1_hit_count", hit_count, 32'd0);
    g0 = rd_grants;
    issue(1'b0, 2'd2, 32'h4, 32'h0, 32'h0DCC_0BAA, 1'b0, lat);
    chk("hit_load_latency", 32'(lat), 32'd1);
    chk("hit_no_refill", 32'(rd_grants - g0), 32'd0);
    chk("hit1_hit_count", hit_count, 32'd1);

    // Byte store hit, then load sees merged word.
    exp_wr_q.push_back('{addr: 32'h4, data: 32'h5555_5555, strb: 4'b0100});
    issue(1'b1, 2'd0, 32'h6, 32'h0000_0055, 32'h0, 1'b0, lat);
    chk("hit_store_latency", 32'(lat), 32'd2);
    issue(1'b0, 2'd2, 32'h4, 32'h0, 32'h0D55_0BAA, 1'b0, lat);
    chk("store_hit_count", hit_count, 32'd3);

    // Conflict eviction.
    issue(1'b0, 2'd2, 32'h404, 32'h0, 32'h1122_3344, 1'b0, lat);
    chk("evict_rd_base", last_rd_base, 32'h400);
    issue(1'b0, 2'd2, 32'h4, 32'h0, 32'h0D55_0BAA, 1'b0, lat);
    chk("evict_miss_count", miss_count, 32'd3);

    // Error requests: no memory traffic, counters untouched.
    g0 = rd_grants;
    w0 = wr_done;
    issue(1'b1, 2'd1, 32'h3, 32'hFFFF, 32'h0, 1'b1, lat);
    chk("err_half_latency", 32'(lat), 32'd1);
    issue(1'b0, 2'd3, 32'h0, 32'h0, 32'h0, 1'b1, lat);
    chk("err_no_refill", 32'(rd_grants - g0), 32'd0);
    chk("err_no_write", 32'(wr_done - w0), 32'd0);
    chk("err_hit_count", hit_count, 32'd3);
    chk("err_miss_count", miss_count, 32'd3);

    // Reset during the 8th refill beat.
    b0 = beats_sent;
    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h44;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while ((beats_sent - b0) < 8 && n < 200);
    chk("abort_reached_beat8", 32'(beats_sent - b0), 32'd8);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_rst_miss_count", miss_count, 32'd0);
    chk("abort_rst_req_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b1;
    b0 = beats_sent;
    issue(1'b0, 2'd2, 32'h44, 32'h0, 32'hA500_0044, 1'b0, lat);
    chk("post_abort_beats", 32'(beats_sent - b0), 32'd16);
    chk("post_abort_miss_count", miss_count, 32'd1);

    // Hit, flush, miss again.
    issue(1'b0, 2'd2, 32'h44, 32'h0, 32'hA500_0044, 1'b0, lat);
    chk("preflush_hit_latency", 32'(lat), 32'd1);
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    b0 = beats_sent;
    issue(1'b0, 2'd2, 32'h44, 32'h0, 32'hA500_0044, 1'b0, lat);
    chk("flush_refill_beats", 32'(beats_sent - b0), 32'd16);
    chk("flush_miss_count", miss_count, 32'd2);

    // Slow write acknowledge holds the FSM in WRITE.
    ack_delay = 5;
    exp_wr_q.push_back('{addr: 32'h48, data: 32'hCAFE_F00D, strb: 4'b1111});
    issue(1'b1, 2'd2, 32'h48, 32'hCAFE_F00D, 32'h0, 1'b0, lat);
    chk("slow_ack_latency", 32'(lat), 32'd7);
    ack_delay = 0;
    issue(1'b0, 2'd2, 32'h48, 32'h0, 32'hCAFE_F00D, 1'b0, lat);
    exp_wr_q.push_back('{addr: 32'h48, data: 32'hBEEF_BEEF, strb: 4'b1100});
    issue(1'b1, 2'd1, 32'h4A, 32'h0000_BEEF, 32'h0, 1'b0, lat);
    issue(1'b0, 2'd2, 32'h48, 32'h0, 32'hBEEF_F00D, 1'b0, lat);

    // Store miss: refill, merge, write-through.
    exp_wr_q.push_back('{addr: 32'h84, data: 32'hABAB_ABAB, strb: 4'b0010});
    b0 = beats_sent;
    issue(1'b1, 2'd0, 32'h85, 32'h0000_00AB, 32'h0, 1'b0, lat);
    chk("store_miss_beats", 32'(beats_sent - b0), 32'd16);
    issue(1'b0, 2'd2, 32'h84, 32'h0, 32'hA500_AB84, 1'b0, lat);
    chk("final_hit_count", hit_count, 32'd6);
    chk("final_miss_count", miss_count, 32'd3);

    repeat (3) @(negedge clock);
    chk("resp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("write_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
